// File: rtl/boxcar_decimator_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : boxcar_decimator_if
// Brief    : Sample-in / decimated-out bundle for boxcar_decimator.
// Revision : 1.0
//------------------------------------------------------------------------------
interface boxcar_decimator_if #(
    parameter int DW = 8
);
    logic                 i_ce;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_overflow;
    logic                 i_clear_ovf;

    // Decimator side
    modport slave (
        input  i_ce,
        input  data_in,
        input  i_ready,
        input  i_clear_ovf,
        output o_data,
        output o_valid,
        output o_overflow
    );

    // Upstream filter plus downstream consumer side
    modport master (
        output i_ce,
        output data_in,
        output i_ready,
        output i_clear_ovf,
        input  o_data,
        input  o_valid,
        input  o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/boxcar_decimator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : boxcar_decimator
// Brief    : Integrate-and-dump by 2^LOG2_N with round-half-up mean and a
//            valid/ready output register that drops results under stall.
// Revision : 1.0
//------------------------------------------------------------------------------
module boxcar_decimator #(
    parameter int DW     = 8,
    parameter int LOG2_N = 2
) (
    input  wire                   clk,
    input  wire                   reset,
    boxcar_decimator_if.slave     bus
);

    localparam int c_N  = 1 << LOG2_N;
    localparam int c_AW = DW + LOG2_N;

    localparam logic [LOG2_N-1:0]  c_CNT_LAST = LOG2_N'(c_N - 1);
    localparam logic signed [c_AW:0] c_HALF   = (c_AW+1)'(1) <<< (LOG2_N - 1);
    localparam logic signed [c_AW:0] c_MAX    = (c_AW+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [c_AW:0] c_MIN    = (c_AW+1)'(-(1 << (DW - 1)));

    logic [LOG2_N-1:0]      r_cnt;
    logic signed [c_AW-1:0] r_acc;
    logic signed [c_AW-1:0] r_dump_sum;
    logic                   r_dump_vld;

    logic signed [DW-1:0]   r_data;
    logic                   r_valid;
    logic                   r_overflow;

    logic signed [c_AW-1:0] w_data_ext;
    logic signed [c_AW-1:0] w_sum;
    logic signed [c_AW:0]   w_rounded;
    logic signed [c_AW:0]   w_shifted;
    logic signed [DW-1:0]   w_result;
    logic                   w_load;
    logic                   w_drop;
    logic                   w_accept;

    assign w_data_ext = {{LOG2_N{bus.data_in[DW-1]}}, bus.data_in};
    assign w_sum      = r_acc + w_data_ext;

    //--------------------------------------------------------------------------
    // Stage 0: integrate N qualified samples, then dump the frame sum.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_dump_sum <= '0;
            r_dump_vld <= 1'b0;
        end else begin
            r_dump_vld <= 1'b0;
            if (bus.i_ce) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_dump_sum <= w_sum;
                    r_dump_vld <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LOG2_N'(1);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stage 1: round half up, divide by N, clamp to the sample range.
    // One extra bit keeps the rounding add from wrapping at the extremes.
    //--------------------------------------------------------------------------
    always_comb begin
        w_rounded = {r_dump_sum[c_AW-1], r_dump_sum} + c_HALF;
        w_shifted = w_rounded >>> LOG2_N;
        if (w_shifted > c_MAX) begin
            w_result = c_MAX[DW-1:0];
        end else if (w_shifted < c_MIN) begin
            w_result = c_MIN[DW-1:0];
        end else begin
            w_result = w_shifted[DW-1:0];
        end
    end

    //--------------------------------------------------------------------------
    // Output register: a held result is never overwritten while stalled.
    //--------------------------------------------------------------------------
    assign w_accept = r_valid && bus.i_ready;
    assign w_load   = r_dump_vld && (!r_valid || bus.i_ready);
    assign w_drop   = r_dump_vld && r_valid && !bus.i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_result;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.i_clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.o_data     = r_data;
    assign bus.o_valid    = r_valid;
    assign bus.o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_boxcar_decimator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_boxcar_decimator
// Brief    : Directed and randomised checks of boxcar_decimator, LOG2_N=2.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_boxcar_decimator;

    logic clk = 1'b0;
    logic reset;
    int   n_errors = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    boxcar_decimator_if #(.DW(8)) bus ();

    boxcar_decimator #(.DW(8), .LOG2_N(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int s);
        bus.i_ce    = 1'b1;
        bus.data_in = 8'(s);
        tick();
        bus.i_ce    = 1'b0;
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d);
        feed(a);
        feed(b);
        feed(c);
        feed(d);
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.i_ce        = 1'b0;
        bus.data_in     = '0;
        bus.i_ready     = 1'b1;
        bus.i_clear_ovf = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data !== 8'sd0 || bus.o_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b data=%0d ovf=%b expected 0 0 0",
                     bus.o_valid, bus.o_data, bus.o_overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bus.i_ready = 1'b1;
        feed4(10, 20, 30, 40);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_early: o_valid=%b expected 0 one clock after 4th sample", bus.o_valid);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'sd25) begin
            n_errors++;
            $display("FAIL basic_result: valid=%b data=%0d expected 1 25", bus.o_valid, bus.o_data);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_single_pulse: o_valid=%b expected 0", bus.o_valid);
        end
    endtask

    task automatic test_rounding();
        feed4(-1, -2, -3, -4);
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== -8'sd2) begin
            n_errors++;
            $display("FAIL round_negative: valid=%b data=%0d expected 1 -2", bus.o_valid, bus.o_data);
        end
        tick();
        feed4(1, 2, 2, 2);
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'sd2) begin
            n_errors++;
            $display("FAIL round_half_up: valid=%b data=%0d expected 1 2", bus.o_valid, bus.o_data);
        end
        tick();
    endtask

    task automatic test_extremes();
        feed4(127, 127, 127, 127);
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'sd127) begin
            n_errors++;
            $display("FAIL extreme_max: valid=%b data=%0d expected 1 127", bus.o_valid, bus.o_data);
        end
        tick();
        feed4(-128, -128, -128, -128);
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== -8'sd128 || bus.o_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL extreme_min: valid=%b data=%0d ovf=%b expected 1 -128 0",
                     bus.o_valid, bus.o_data, bus.o_overflow);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.i_ready = 1'b0;
        feed4(4, 4, 4, 4);
        feed4(8, 8, 8, 8);
        n_checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_data !== 8'sd4) begin
            n_errors++;
            $display("FAIL stall_before_drop: valid=%b data=%0d ovf=%b expected 1 4 0",
                     bus.o_valid, bus.o_data, bus.o_overflow);
        end
        tick();
        n_checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_data !== 8'sd4) begin
            n_errors++;
            $display("FAIL stall_drop: valid=%b data=%0d ovf=%b expected 1 4 1",
                     bus.o_valid, bus.o_data, bus.o_overflow);
        end
        bus.i_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: valid=%b ovf=%b expected 0 1", bus.o_valid, bus.o_overflow);
        end
        bus.i_clear_ovf = 1'b1;
        tick();
        bus.i_clear_ovf = 1'b0;
        n_checks++;
        if (bus.o_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: ovf=%b expected 0", bus.o_overflow);
        end
    endtask

    task automatic test_reset_midframe();
        feed(5);
        feed(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        feed4(1, 1, 1, 1);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_no_partial: o_valid=%b expected 0", bus.o_valid);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'sd1) begin
            n_errors++;
            $display("FAIL midreset_result: valid=%b data=%0d expected 1 1", bus.o_valid, bus.o_data);
        end
        tick();
    endtask

    task automatic test_sparse_ce();
        for (int i = 0; i < 4; i++) begin
            feed(8);
            if (i < 3) begin
                tick();
                tick();
            end
        end
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL sparse_early: o_valid=%b expected 0", bus.o_valid);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'sd8) begin
            n_errors++;
            $display("FAIL sparse_result: valid=%b data=%0d expected 1 8", bus.o_valid, bus.o_data);
        end
        tick();
    endtask

    task automatic test_random();
        int q[$];
        int sum;
        int cnt;
        int sent;
        int outs;
        int drain;
        int s;
        int e;
        bit ce;
        sum   = 0;
        cnt   = 0;
        sent  = 0;
        outs  = 0;
        drain = 0;
        bus.i_ready = 1'b1;
        for (int it = 0; it < 1000 && (sent < 64 || drain < 4); it++) begin
            if (sent < 64) begin
                ce = 1'($urandom_range(0, 1));
                s  = int'($urandom_range(0, 255)) - 128;
            end else begin
                ce = 1'b0;
                s  = 0;
                drain++;
            end
            bus.i_ce    = ce;
            bus.data_in = 8'(s);
            if (ce) begin
                sum += s;
                cnt++;
                sent++;
                if (cnt == 4) begin
                    e = (sum + 2) >>> 2;
                    if (e > 127) e = 127;
                    if (e < -128) e = -128;
                    q.push_back(e);
                    sum = 0;
                    cnt = 0;
                end
            end
            tick();
            if (bus.o_valid === 1'b1) begin
                outs++;
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL random_spurious: data=%0d with no expected result", bus.o_data);
                end else begin
                    e = q.pop_front();
                    if (bus.o_data !== 8'(e)) begin
                        n_errors++;
                        $display("FAIL random_data: data=%0d expected %0d", bus.o_data, e);
                    end
                end
            end
        end
        bus.i_ce = 1'b0;
        n_checks++;
        if (outs != 16 || q.size() != 0) begin
            n_errors++;
            $display("FAIL random_count: outputs=%0d pending=%0d expected 16 0", outs, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_extremes();
        test_backpressure();
        test_reset_midframe();
        test_sparse_ce();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
